ajuste_campo: RTL and testbench

Parametrised time-field adjuster for the clock/alarm setting path. Debounces an up and a down push-button on a slow sampling tick, steps a modulo-N field value with wrap in both directions, and auto-repeats while a button is held. It is instantiated once per field (minutes, hours, seconds) between the board buttons/switches and the timekeeping core, which receives the gated value and a commit pulse.

---
 rtl/ajuste_pkg.sv | 19 +
 rtl/ajuste_debounce.sv | 33 +++
 rtl/ajuste_campo.sv | 173 +++++++++++++++++
 tb/tb_ajuste_campo.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ajuste_pkg.sv
// rtl/ajuste_pkg.sv - shared types and defaults for the time-field adjuster
package ajuste_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DOWN = 2'd2
   } dir_t;

   // 2.5 ms sampling tick at a 100 MHz system clock
   localparam int TICK_DIV_DEFAULT = 250000;

endpackage

// File: rtl/ajuste_debounce.sv
// rtl/ajuste_debounce.sv - tick-sampled three-flop button filter with press/held decode
module ajuste_debounce (
   input  logic clkS,
   input  logic rst_n,
   input  logic tick,
   input  logic raw,
   output logic press,
   output logic held
);

   logic [2:0] sync_q;
   logic [2:0] sync_d;

   always_comb begin
      sync_d = sync_q;
      if (tick) begin
         sync_d = {sync_q[1:0], raw};
      end
   end

   always_ff @(posedge clkS or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   // A single sampled high is enough for a press; anything between samples is never seen.
   assign press = sync_q[1] & ~sync_q[2] & tick;
   assign held  = sync_q[1] & sync_q[2];

endmodule

// File: rtl/ajuste_campo.sv
// rtl/ajuste_campo.sv - modulo-N field adjuster with debounced up/down buttons and auto-repeat
module ajuste_campo
   import ajuste_pkg::*;
#(
   parameter int MODULO       = 60,
   parameter int WIDTH        = 6,
   parameter int TICK_DIV     = TICK_DIV_DEFAULT,
   parameter int REPEAT_DELAY = 200,
   parameter int REPEAT_RATE  = 40
) (
   input  logic             clkS,
   input  logic             rst_n,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             adj_en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] adj_out,
   output logic             step,
   output logic             commit
);

   localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int HW   = $clog2(HMAX + 1);
   localparam int WP1  = WIDTH + 1;

   localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [HW-1:0]    DELAY_END = HW'(REPEAT_DELAY);
   localparam logic [HW-1:0]    RATE_END  = HW'(REPEAT_RATE);
   localparam logic [WIDTH-1:0] VAL_MAX   = WIDTH'(MODULO - 1);
   localparam logic [WIDTH:0]   VAL_LIMIT = WP1'(MODULO);

   logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
   logic             tick;
   logic             up_press, up_held, dn_press, dn_held;
   state_t           state_q, state_d;
   dir_t             dir_q, dir_d;
   logic [HW-1:0]    hold_q, hold_d, hold_inc;
   logic             fire;
   dir_t             fire_dir;
   logic             own_held, other_held;
   logic [WIDTH-1:0] value_q, value_d;
   logic [WIDTH-1:0] adj_out_q, adj_out_d;
   logic [WIDTH-1:0] load_sat;
   logic             adj_s_q, adj_s_d;
   logic             commit_q, commit_d;
   logic             step_ok;

   assign tick = (tick_cnt_q == TICK_LAST);

   always_comb begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   end

   ajuste_debounce u_deb_up (
      .clkS  (clkS),
      .rst_n (rst_n),
      .tick  (tick),
      .raw   (btn_up),
      .press (up_press),
      .held  (up_held)
   );

   ajuste_debounce u_deb_dn (
      .clkS  (clkS),
      .rst_n (rst_n),
      .tick  (tick),
      .raw   (btn_down),
      .press (dn_press),
      .held  (dn_held)
   );

   assign own_held   = (dir_q == DIR_UP) ? up_held : dn_held;
   assign other_held = (dir_q == DIR_UP) ? dn_held : up_held;
   assign hold_inc   = hold_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      hold_d   = hold_q;
      fire     = 1'b0;
      fire_dir = DIR_NONE;
      case (state_q)
         IDLE: begin
            // Simultaneous presses cancel each other out.
            if (up_press ^ dn_press) begin
               fire     = 1'b1;
               fire_dir = up_press ? DIR_UP : DIR_DOWN;
               dir_d    = fire_dir;
               hold_d   = '0;
               state_d  = DELAY;
            end
         end
         DELAY, REPEAT: begin
            fire_dir = dir_q;
            if (tick) begin
               if (!own_held || other_held) begin
                  state_d = IDLE;
                  dir_d   = DIR_NONE;
                  hold_d  = '0;
               end else if ((state_q == DELAY) && (hold_inc == DELAY_END)) begin
                  fire    = 1'b1;
                  hold_d  = '0;
                  state_d = REPEAT;
               end else if ((state_q == REPEAT) && (hold_inc == RATE_END)) begin
                  fire    = 1'b1;
                  hold_d  = '0;
               end else begin
                  hold_d  = hold_inc;
               end
            end
         end
         default: begin
            state_d = IDLE;
            dir_d   = DIR_NONE;
            hold_d  = '0;
         end
      endcase
   end

   assign load_sat = ({1'b0, load_val} >= VAL_LIMIT) ? VAL_MAX : load_val;
   assign step_ok  = fire & adj_en & ~load;

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_sat;
      end else if (step_ok) begin
         if (fire_dir == DIR_UP) begin
            value_d = (value_q == VAL_MAX) ? '0 : value_q + 1'b1;
         end else begin
            value_d = (value_q == '0) ? VAL_MAX : value_q - 1'b1;
         end
      end
   end

   always_comb begin
      adj_out_d = adj_en ? value_q : '0;
      adj_s_d   = adj_en;
      // Falling edge seen between the sync flop and the live switch level.
      commit_d  = adj_s_q & ~adj_en;
   end

   always_ff @(posedge clkS or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt_q <= '0;
         state_q    <= IDLE;
         dir_q      <= DIR_NONE;
         hold_q     <= '0;
         value_q    <= '0;
         adj_out_q  <= '0;
         adj_s_q    <= 1'b0;
         commit_q   <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         state_q    <= state_d;
         dir_q      <= dir_d;
         hold_q     <= hold_d;
         value_q    <= value_d;
         adj_out_q  <= adj_out_d;
         adj_s_q    <= adj_s_d;
         commit_q   <= commit_d;
      end
   end

   assign value   = value_q;
   assign adj_out = adj_out_q;
   assign step    = step_ok;
   assign commit  = commit_q;

endmodule

// File: tb/tb_ajuste_campo.sv
// tb/tb_ajuste_campo.sv - scoreboard bench for ajuste_campo with a tick-level reference model
module tb_ajuste_campo;

   localparam int TD = 4;
   localparam int M  = 60;
   localparam int W  = 6;
   localparam int RD = 3;
   localparam int RR = 2;

   logic         clkS = 1'b0;
   logic         rst_n = 1'b0;
   logic         btn_up = 1'b0;
   logic         btn_down = 1'b0;
   logic         adj_en = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] value;
   logic [W-1:0] adj_out;
   logic         step;
   logic         commit;

   always #5 clkS = ~clkS;

   ajuste_campo #(
      .MODULO       (M),
      .WIDTH        (W),
      .TICK_DIV     (TD),
      .REPEAT_DELAY (RD),
      .REPEAT_RATE  (RR)
   ) dut (
      .clkS     (clkS),
      .rst_n    (rst_n),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .adj_en   (adj_en),
      .load     (load),
      .load_val (load_val),
      .value    (value),
      .adj_out  (adj_out),
      .step     (step),
      .commit   (commit)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int step_q[$];
   int commit_q[$];
   int steps_seen = 0;
   int commits_seen = 0;

   // Reference model: button levels as sampled at ticks, hold measured in elapsed ticks.
   int m_tcnt, m_tick, m_ptick, m_dir, m_val, m_adj;
   bit m_act, m_adjs;
   bit ua1, ua2, ua3, da1, da2, da3;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_tcnt = 0; m_tick = 0; m_ptick = 0; m_dir = 0; m_val = 0; m_adj = 0;
      m_act = 0; m_adjs = 0;
      ua1 = 0; ua2 = 0; ua3 = 0; da1 = 0; da2 = 0; da3 = 0;
   endtask

   task automatic model_eval();
      bit fire, pu, pd, hu, hd, own, oth;
      int e, new_adj;
      fire = 0;
      if (m_tcnt == TD - 1) begin
         pu = ua2 & ~ua3;
         pd = da2 & ~da3;
         hu = ua2 & ua3;
         hd = da2 & da3;
         if (m_act) begin
            own = (m_dir == 1) ? hu : hd;
            oth = (m_dir == 1) ? hd : hu;
            e = m_tick - m_ptick;
            if (!own || oth) m_act = 0;
            else if (e == RD || (e > RD && (e - RD) % RR == 0)) fire = 1;
         end else if (pu != pd) begin
            m_act = 1;
            m_dir = pu ? 1 : 2;
            m_ptick = m_tick;
            fire = 1;
         end
         ua3 = ua2; ua2 = ua1; ua1 = btn_up;
         da3 = da2; da2 = da1; da1 = btn_down;
         m_tick++;
      end
      m_tcnt = (m_tcnt + 1) % TD;
      new_adj = adj_en ? m_val : 0;
      if (load) begin
         m_val = (int'(load_val) > M - 1) ? M - 1 : int'(load_val);
      end else if (fire && adj_en) begin
         if (m_dir == 1) m_val = (m_val + 1) % M;
         else m_val = (m_val + M - 1) % M;
         step_q.push_back(m_val);
      end
      m_adj = new_adj;
      if (m_adjs && !adj_en) commit_q.push_back(cyc + 1);
      m_adjs = adj_en;
   endtask

   task automatic tick_cyc();
      model_eval();
      @(posedge clkS);
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      repeat (n) tick_cyc();
   endtask

   task automatic align(input int t);
      while (m_tcnt != t) tick_cyc();
   endtask

   task automatic do_load(input int v);
      load_val = W'(v);
      load = 1'b1;
      tick_cyc();
      load = 1'b0;
   endtask

   task automatic check_state(input string tag);
      check({tag, "_value_model"}, int'(value), m_val);
      check({tag, "_adj_out_model"}, int'(adj_out), m_adj);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_value"}, int'(value), 0);
      check({tag, "_adj_out"}, int'(adj_out), 0);
      check({tag, "_step"}, int'(step), 0);
      check({tag, "_commit"}, int'(commit), 0);
   endtask

   initial begin : step_monitor
      int exp;
      forever begin
         @(negedge clkS);
         if (step === 1'b1) begin
            steps_seen++;
            if (step_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL step_unexpected: got step=1 expected step=0 (cycle %0d value %0d)", cyc, value);
            end else begin
               exp = step_q.pop_front();
               @(posedge clkS);
               #2;
               check("step_value", int'(value), exp);
            end
         end
      end
   end

   initial begin : commit_monitor
      forever begin
         @(negedge clkS);
         if (commit === 1'b1) begin
            commits_seen++;
            if (commit_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL commit_unexpected: got commit=1 expected commit=0 (cycle %0d)", cyc);
            end else begin
               check("commit_cycle", cyc, commit_q.pop_front());
            end
         end
      end
   end

   initial begin : driver
      int s0, c0, r;
      model_reset();
      repeat (2) @(posedge clkS);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      model_reset();

      adj_en = 1'b1;
      run(4);

      // single up press from 0
      align(0);
      btn_up = 1'b1;
      run(2 * TD);
      btn_up = 1'b0;
      run(6 * TD);
      check("single_up_value", int'(value), 1);
      check("single_up_adj_out", int'(adj_out), 1);
      check_state("single_up");

      // wrap in both directions
      do_load(59);
      align(0);
      btn_up = 1'b1;
      run(2 * TD);
      btn_up = 1'b0;
      run(5 * TD);
      check("wrap_up", int'(value), 0);
      do_load(0);
      align(0);
      btn_down = 1'b1;
      run(2 * TD);
      btn_down = 1'b0;
      run(5 * TD);
      check("wrap_down", int'(value), 59);

      // held down with auto-repeat
      do_load(10);
      align(0);
      s0 = steps_seen;
      btn_down = 1'b1;
      run(10 * TD);
      btn_down = 1'b0;
      run(5 * TD);
      check("hold_down_value", int'(value), 5);
      check("hold_down_steps", steps_seen - s0, 5);
      check_state("hold_down");

      // both buttons together, then a short bounce between samples
      align(0);
      btn_up = 1'b1;
      btn_down = 1'b1;
      run(3 * TD);
      btn_up = 1'b0;
      btn_down = 1'b0;
      run(5 * TD);
      check("both_value", int'(value), 5);
      align(0);
      btn_up = 1'b1;
      run(2);
      btn_up = 1'b0;
      run(6 * TD);
      check("bounce_value", int'(value), 5);

      // load coinciding with the press tick
      align(0);
      s0 = steps_seen;
      btn_up = 1'b1;
      run(11);
      load_val = 6'd63;
      load = 1'b1;
      tick_cyc();
      load = 1'b0;
      btn_up = 1'b0;
      run(6 * TD);
      check("load_over_step_value", int'(value), 59);
      check("load_over_step_steps", steps_seen - s0, 0);

      // adjust disabled: frozen value, zero adj_out, one commit
      c0 = commits_seen;
      adj_en = 1'b0;
      run(2);
      align(0);
      btn_up = 1'b1;
      run(2 * TD);
      btn_up = 1'b0;
      run(5 * TD);
      check("disabled_value", int'(value), 59);
      check("disabled_adj_out", int'(adj_out), 0);
      check("commit_count", commits_seen - c0, 1);
      adj_en = 1'b1;
      run(4);

      // reset during auto-repeat with the button kept held
      align(0);
      btn_up = 1'b1;
      run(8 * TD);
      align(1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_repeat_reset");
      repeat (3) begin
         @(posedge clkS);
         #1;
         cyc++;
      end
      rst_n = 1'b1;
      model_reset();
      run(14);
      check("post_reset_press", int'(value), 1);
      run(12);
      check("post_reset_repeat", int'(value), 2);
      btn_up = 1'b0;
      run(5 * TD);
      check_state("post_reset");

      // randomized segments against the model
      repeat (60) begin
         r = $urandom_range(0, 9);
         btn_up = (r < 3) || (r == 9);
         btn_down = ((r >= 3) && (r < 6)) || (r == 9);
         if ($urandom_range(0, 7) == 0) adj_en = ~adj_en;
         if ($urandom_range(0, 5) == 0) do_load($urandom_range(0, 63));
         run($urandom_range(1, 40));
      end
      btn_up = 1'b0;
      btn_down = 1'b0;
      adj_en = 1'b1;
      run(10 * TD);
      check_state("random_end");
      check("step_queue_drained", step_q.size(), 0);
      check("commit_queue_drained", commit_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
